// File: rtl/simd_execute_stage.sv
// SIMD execute stage: lane-wise 256-bit vector ALU with operand forwarding and multi-cycle MUL/MAC.
// Define SIMD_SAT_EN to saturate ADD/SUB and the MAC readout instead of wrapping.
module simd_execute_stage #(
  parameter int unsigned LANES   = 16,
  parameter int unsigned LANE_W  = 16,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned FRAC    = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RegWriteE,
  input  logic                      ResultSrcE,
  input  logic                      MemWriteE,
  input  logic [2:0]                ALUControlE,
  input  logic                      ALUSrcE,
  input  logic [LANES*LANE_W-1:0]   RD1E,
  input  logic [LANES*LANE_W-1:0]   RD2E,
  input  logic [LANES*LANE_W-1:0]   ImmExtE,
  input  logic [LANES*LANE_W-1:0]   PCPlus4E,
  input  logic [4:0]                RdE,
  input  logic [1:0]                ForwardAE,
  input  logic [1:0]                ForwardBE,
  input  logic [LANES*LANE_W-1:0]   ResultW,
  input  logic                      FlushE,
  output logic                      StallE,
  output logic                      RegWriteM,
  output logic                      ResultSrcM,
  output logic                      MemWriteM,
  output logic [LANES*LANE_W-1:0]   ALUResultM,
  output logic [LANES*LANE_W-1:0]   WriteDataM,
  output logic [LANES*LANE_W-1:0]   PCPlus4M,
  output logic [4:0]                RdM
);
  localparam int unsigned VW = LANES * LANE_W;
  localparam int unsigned AW = 2 * LANE_W;
  localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_MAC = 3'b101;
  localparam logic [2:0] OP_CLR = 3'b110;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [VW-1:0]   a_h_q, b_h_q, wd_h_q, pc_h_q;
  logic [2:0]      op_h_q;
  logic            rw_h_q, rs_h_q, mw_h_q;
  logic [4:0]      rd_h_q;
  logic [AW-1:0]   acc_q [LANES];

  logic [VW-1:0]        fwd_a, fwd_b, src_b, op_a, op_b, res_d;
  logic [AW-1:0]        acc_d [LANES];
  logic [AW+LANE_W-1:0] lane_out;
  logic [2:0]           op;
  logic                 busy, is_multi;

  function automatic logic [VW-1:0] fwd_mux(input logic [1:0] sel, input logic [VW-1:0] rd,
                                            input logic [VW-1:0] res_w, input logic [VW-1:0] alu_m);
    case (sel)
      2'b01:   return res_w;
      2'b10:   return alu_m;
      default: return rd;
    endcase
  endfunction

  // Clip a sign-extended LANE_W+1 bit sum/difference back to one lane.
  function automatic logic [LANE_W-1:0] clip_sum(input logic [LANE_W:0] s);
`ifdef SIMD_SAT_EN
    if (s[LANE_W] != s[LANE_W-1]) return {s[LANE_W], {(LANE_W-1){~s[LANE_W]}}};
`endif
    return s[LANE_W-1:0];
  endfunction

  function automatic logic [LANE_W-1:0] mac_read(input logic [AW-1:0] sh);
`ifdef SIMD_SAT_EN
    if (sh[AW-1:LANE_W-1] != {(AW-LANE_W+1){sh[AW-1]}})
      return {sh[AW-1], {(LANE_W-1){~sh[AW-1]}}};
`endif
    return sh[LANE_W-1:0];
  endfunction

  // Returns {acc_new, result} for one lane.
  function automatic logic [AW+LANE_W-1:0] lane_alu(input logic [2:0] f, input logic [LANE_W-1:0] a,
                                                    input logic [LANE_W-1:0] b, input logic [AW-1:0] acc);
    logic [LANE_W:0] sum, dif;
    logic [AW-1:0]   prod, mac, sh, acc_new;
    logic [LANE_W-1:0] r;
    sum  = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    dif  = {a[LANE_W-1], a} - {b[LANE_W-1], b};
    prod = $signed({{LANE_W{a[LANE_W-1]}}, a}) * $signed({{LANE_W{b[LANE_W-1]}}, b});
    mac  = acc + prod;
    sh   = $signed(mac) >>> FRAC;
    acc_new = acc;
    r       = '0;
    case (f)
      OP_ADD:  r = clip_sum(sum);
      OP_SUB:  r = clip_sum(dif);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_MUL:  r = prod[LANE_W-1:0];
      OP_MAC:  begin acc_new = mac; r = mac_read(sh); end
      OP_CLR:  acc_new = '0;
      default: r = b;
    endcase
    return {acc_new, r};
  endfunction

  // Operand selection: live forwarded operands in IDLE, captured operands while BUSY.
  always_comb begin
    fwd_a    = fwd_mux(ForwardAE, RD1E, ResultW, ALUResultM);
    fwd_b    = fwd_mux(ForwardBE, RD2E, ResultW, ALUResultM);
    src_b    = ALUSrcE ? ImmExtE : fwd_b;
    busy     = (state_q == BUSY);
    is_multi = (ALUControlE == OP_MUL) || (ALUControlE == OP_MAC);
    op       = busy ? op_h_q : ALUControlE;
    op_a     = busy ? a_h_q : fwd_a;
    op_b     = busy ? b_h_q : src_b;
    res_d    = '0;
    lane_out = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_out = lane_alu(op, op_a[i*LANE_W +: LANE_W], op_b[i*LANE_W +: LANE_W], acc_q[i]);
      res_d[i*LANE_W +: LANE_W] = lane_out[LANE_W-1:0];
      acc_d[i] = lane_out[AW+LANE_W-1:LANE_W];
    end
    StallE = 1'b0;
    if (!rst && !FlushE) StallE = busy ? (cnt_q != '0) : is_multi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_h_q      <= '0;
      b_h_q      <= '0;
      wd_h_q     <= '0;
      pc_h_q     <= '0;
      op_h_q     <= '0;
      rw_h_q     <= 1'b0;
      rs_h_q     <= 1'b0;
      mw_h_q     <= 1'b0;
      rd_h_q     <= '0;
      RegWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else begin
      // Bubble unless a result commits this cycle.
      RegWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      if (state_q == IDLE) begin
        if (!FlushE && is_multi) begin
          state_q <= BUSY;
          cnt_q   <= CW'(MUL_LAT - 1);
          a_h_q   <= fwd_a;
          b_h_q   <= src_b;
          wd_h_q  <= fwd_b;
          pc_h_q  <= PCPlus4E;
          op_h_q  <= ALUControlE;
          rw_h_q  <= RegWriteE;
          rs_h_q  <= ResultSrcE;
          mw_h_q  <= MemWriteE;
          rd_h_q  <= RdE;
        end else if (!FlushE) begin
          RegWriteM  <= RegWriteE;
          ResultSrcM <= ResultSrcE;
          MemWriteM  <= MemWriteE;
          ALUResultM <= res_d;
          WriteDataM <= fwd_b;
          PCPlus4M   <= PCPlus4E;
          RdM        <= RdE;
          for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
        end
      end else begin
        if (FlushE) begin
          state_q <= IDLE;
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - CW'(1);
        end else begin
          state_q    <= IDLE;
          RegWriteM  <= rw_h_q;
          ResultSrcM <= rs_h_q;
          MemWriteM  <= mw_h_q;
          ALUResultM <= res_d;
          WriteDataM <= wd_h_q;
          PCPlus4M   <= pc_h_q;
          RdM        <= rd_h_q;
          for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_simd_execute_stage.sv
// Directed bench for simd_execute_stage: forwarding, single-cycle ops, MUL/MAC stalls, flush and reset.
module tb_simd_execute_stage;
  localparam int unsigned MUL_LAT = 2;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] MUL = 3'b100, MAC = 3'b101, CLR = 3'b110, MOVB = 3'b111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, FlushE;
  logic [2:0]   ALUControlE;
  logic [255:0] RD1E, RD2E, ImmExtE, PCPlus4E, ResultW;
  logic [4:0]   RdE;
  logic [1:0]   ForwardAE, ForwardBE;
  logic         StallE, RegWriteM, ResultSrcM, MemWriteM;
  logic [255:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]   RdM;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  simd_execute_stage #(.LANES(16), .LANE_W(16), .MUL_LAT(MUL_LAT), .FRAC(15)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW), .FlushE(FlushE),
    .StallE(StallE), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  function automatic logic [255:0] rep(input logic [15:0] x);
    return {16{x}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    RegWriteE = 1'b0; ResultSrcE = 1'b0; MemWriteE = 1'b0; ALUControlE = ADD; ALUSrcE = 1'b0;
    RD1E = '0; RD2E = '0; ImmExtE = '0; PCPlus4E = '0; RdE = '0;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = '0; FlushE = 1'b0;
  endtask

  task automatic op(input logic [2:0] c, input logic [255:0] a, input logic [255:0] b,
                    input logic rw, input logic [4:0] rd);
    nop();
    ALUControlE = c; RD1E = a; RD2E = b; RegWriteE = rw; RdE = rd; PCPlus4E = rep(16'h0040);
  endtask

  // Inputs already applied; walks stall/bubble cycles and checks the committed result.
  task automatic run_multi(input string tag, input logic [255:0] exp_res, input logic [255:0] exp_wd,
                           input logic [255:0] exp_pc, input logic exp_mw, input logic [4:0] exp_rd);
    #1 chkb({tag, "_stall_start"}, 5'(StallE), 5'd1);
    for (int k = 0; k < MUL_LAT; k++) begin
      tick();
      ResultW = ~ResultW;
      chkb({tag, "_bubble_rw"}, 5'(RegWriteM), 5'd0);
      chk({tag, "_bubble_alu"}, ALUResultM, '0);
      chkb({tag, "_stall_busy"}, 5'(StallE), (k < MUL_LAT - 1) ? 5'd1 : 5'd0);
    end
    tick();
    chk({tag, "_res"}, ALUResultM, exp_res);
    chk({tag, "_wd"}, WriteDataM, exp_wd);
    chk({tag, "_pc"}, PCPlus4M, exp_pc);
    chkb({tag, "_rw"}, 5'(RegWriteM), 5'd1);
    chkb({tag, "_mw"}, 5'(MemWriteM), 5'(exp_mw));
    chkb({tag, "_rd"}, RdM, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    nop();
    tick();
    tick();
    ALUControlE = MAC;
    #1;
    chkb("rst_rw", 5'(RegWriteM), 5'd0);
    chk("rst_alu", ALUResultM, '0);
    chkb("rst_rd", RdM, 5'd0);
    chkb("rst_stall_mac_pending", 5'(StallE), 5'd0);
    nop();
    rst = 1'b0;
    tick();

    // Reset in the first BUSY cycle of a MAC
    op(MAC, rep(16'h4000), rep(16'h4000), 1'b1, 5'd5);
    #1 chkb("midrst_stall_start", 5'(StallE), 5'd1);
    tick();
    rst = 1'b1;
    #1;
    chkb("midrst_rw", 5'(RegWriteM), 5'd0);
    chk("midrst_alu", ALUResultM, '0);
    chkb("midrst_stall", 5'(StallE), 5'd0);
    nop();
    tick();
    rst = 1'b0;
    #1 chkb("postrst_stall", 5'(StallE), 5'd0);
    tick();

    op(MAC, rep(16'h4000), rep(16'h4000), 1'b1, 5'd5);
    run_multi("mac1", rep(16'h2000), rep(16'h4000), rep(16'h0040), 1'b0, 5'd5);
    op(MAC, rep(16'h4000), rep(16'h4000), 1'b1, 5'd5);
    run_multi("mac2", rep(16'h4000), rep(16'h4000), rep(16'h0040), 1'b0, 5'd5);

    op(CLR, rep(16'h1234), rep(16'h0001), 1'b1, 5'd6);
    #1 chkb("clr_stall", 5'(StallE), 5'd0);
    tick();
    chk("clr_res", ALUResultM, '0);
    chkb("clr_rd", RdM, 5'd6);

    // Flush in BUSY aborts without touching the accumulator
    op(MAC, rep(16'h4000), rep(16'h4000), 1'b1, 5'd5);
    #1 chkb("flush_busy_stall_start", 5'(StallE), 5'd1);
    tick();
    FlushE = 1'b1;
    #1 chkb("flush_busy_stall", 5'(StallE), 5'd0);
    tick();
    chkb("flush_busy_rw", 5'(RegWriteM), 5'd0);
    chk("flush_busy_alu", ALUResultM, '0);
    chkb("flush_busy_rd", RdM, 5'd0);
    op(MAC, rep(16'h4000), rep(16'h4000), 1'b1, 5'd5);
    run_multi("mac_after_flush", rep(16'h2000), rep(16'h4000), rep(16'h0040), 1'b0, 5'd5);

    op(MOVB, rep(16'h1234), rep(16'h5555), 1'b1, 5'd8);
    ALUSrcE = 1'b1; ImmExtE = rep(16'h0001);
    tick();
    chk("movb_res", ALUResultM, rep(16'h0001));
    chk("movb_wd", WriteDataM, rep(16'h5555));

    op(ADD, rep(16'h1234), rep(16'h0002), 1'b1, 5'd7);
    ForwardAE = 2'b10;
    tick();
    chk("add_fwdm_res", ALUResultM, rep(16'h0003));
    chkb("add_fwdm_rw", 5'(RegWriteM), 5'd1);
    chkb("add_fwdm_rd", RdM, 5'd7);
    chk("add_fwdm_pc", PCPlus4M, rep(16'h0040));

    op(AND_, rep(16'h0F0F), rep(16'h00FF), 1'b0, 5'd9);
    ForwardAE = 2'b11;
    tick();
    chk("and_fwd11_res", ALUResultM, rep(16'h000F));
    chkb("and_fwd11_rw", 5'(RegWriteM), 5'd0);

    op(SUB, rep(16'h000A), rep(16'h7777), 1'b1, 5'd10);
    ForwardBE = 2'b01; ResultW = rep(16'h0003);
    tick();
    chk("sub_fwdw_res", ALUResultM, rep(16'h0007));
    chk("sub_fwdw_wd", WriteDataM, rep(16'h0003));

    op(OR_, rep(16'hF000), rep(16'h000F), 1'b1, 5'd11);
    ResultSrcE = 1'b1; MemWriteE = 1'b1;
    tick();
    chk("or_res", ALUResultM, rep(16'hF00F));
    chkb("or_rs", 5'(ResultSrcM), 5'd1);
    chkb("or_mw", 5'(MemWriteM), 5'd1);

    op(ADD, rep(16'h7FFF), rep(16'h0001), 1'b1, 5'd12);
    tick();
`ifdef SIMD_SAT_EN
    chk("add_ovf", ALUResultM, rep(16'h7FFF));
`else
    chk("add_ovf", ALUResultM, rep(16'h8000));
`endif
    op(SUB, rep(16'h8000), rep(16'h0001), 1'b1, 5'd12);
    tick();
`ifdef SIMD_SAT_EN
    chk("sub_ovf", ALUResultM, rep(16'h8000));
`else
    chk("sub_ovf", ALUResultM, rep(16'h7FFF));
`endif

    op(ADD, rep(16'h0001), rep(16'h0001), 1'b1, 5'd13);
    FlushE = 1'b1;
    tick();
    chkb("flush_idle_rw", 5'(RegWriteM), 5'd0);
    chk("flush_idle_alu", ALUResultM, '0);
    chkb("flush_idle_rd", RdM, 5'd0);

    op(MAC, rep(16'h4000), rep(16'h4000), 1'b1, 5'd5);
    FlushE = 1'b1;
    #1 chkb("flush_idle_mac_stall", 5'(StallE), 5'd0);
    tick();
    op(ADD, rep(16'h0002), rep(16'h0003), 1'b1, 5'd3);
    #1 chkb("after_flush_mac_stall", 5'(StallE), 5'd0);
    tick();
    chk("after_flush_mac_res", ALUResultM, rep(16'h0005));

    // MUL with forwarded A from ResultW and immediate B; ResultW is scrambled while BUSY
    op(MUL, rep(16'h7777), rep(16'h0055), 1'b1, 5'd14);
    ForwardAE = 2'b01; ResultW = rep(16'h0003);
    ALUSrcE = 1'b1; ImmExtE = rep(16'hFFFF); PCPlus4E = rep(16'hABCD); MemWriteE = 1'b1;
    run_multi("mul", rep(16'hFFFD), rep(16'h0055), rep(16'hABCD), 1'b1, 5'd14);

    op(MAC, rep(16'h4000), rep(16'h4000), 1'b1, 5'd5);
    run_multi("mac_after_mul", rep(16'h4000), rep(16'h4000), rep(16'h0040), 1'b0, 5'd5);

    nop();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
